// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: COM-aligned serial-to-parallel receiver.
// Define S2P_IDLE_EXIT_EN to drop the link on an 8'h7C electrical-idle symbol.
module serial_to_parallel_rx #(
    parameter int                   DATA_SIZE  = 8,
    parameter logic [DATA_SIZE-1:0] COM_SYMBOL = 8'hBC,
    parameter int                   COM_COUNT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 active
);
    localparam int BCW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int CW  = $clog2(COM_COUNT + 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

    state_t               r_state, w_next;
    logic [DATA_SIZE-1:0] r_sr, w_cand, w_data;
    logic [BCW-1:0]       r_bc, w_bc;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic                 w_valid, w_bnd, w_com, w_idle;

    assign w_cand = {r_sr[DATA_SIZE-2:0], data_in};
    assign w_bnd  = r_bc == BCW'(DATA_SIZE - 1);
    assign w_com  = w_cand == COM_SYMBOL;
`ifdef S2P_IDLE_EXIT_EN
    assign w_idle = w_cand == DATA_SIZE'(8'h7C);
`else
    assign w_idle = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_bc    = w_bnd ? '0 : r_bc + 1'b1;
        w_cnt   = r_cnt;
        w_data  = data_out;
        w_valid = 1'b0;
        case (r_state)
            SEARCH: begin
                // Any bit phase may complete a COM, so bc restarts here.
                if (w_com) begin
                    w_next = (COM_COUNT <= 1) ? ACTIVE : ALIGN;
                    w_bc   = '0;
                    w_cnt  = CW'(1);
                end
            end
            ALIGN: begin
                if (w_bnd && w_com) begin
                    w_cnt  = r_cnt + 1'b1;
                    w_next = (w_cnt == CW'(COM_COUNT)) ? ACTIVE : ALIGN;
                end else if (w_bnd) begin
                    w_next = SEARCH;
                    w_cnt  = '0;
                end
            end
            ACTIVE: begin
                if (w_bnd && !w_com && w_idle) begin
                    w_next = SEARCH;
                    w_cnt  = '0;
                end else if (w_bnd && !w_com) begin
                    w_data  = w_cand;
                    w_valid = 1'b1;
                end
            end
            default: w_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= SEARCH;
            r_sr      <= '0;
            r_bc      <= '0;
            r_cnt     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sr      <= w_cand;
            r_bc      <= w_bc;
            r_cnt     <= w_cnt;
            data_out  <= w_data;
            valid_out <= w_valid;
            active    <= w_next == ACTIVE;
        end
    end
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: directed serial stimulus with a scoreboard of expected symbols.
module tb_serial_to_parallel_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, active;

    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    int         t_a5 = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] sb[$];

    serial_to_parallel_rx dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .active(active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp);
        if (exp) sb.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            data_in = b[i];
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid_out strobe must match the oldest expected symbol.
    always @(negedge clk) begin
        if (reset && valid_out) begin
            if (sb.size() == 0) chk("unexpected_valid", {24'd0, data_out}, 0);
            else chk("sb_data", {24'd0, data_out}, {24'd0, sb.pop_front()});
        end
        if (valid_out && prev_valid) chk("valid_back_to_back", 1, 0);
        prev_valid <= valid_out;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data_out", {24'd0, data_out}, 0);
        chk("rst_valid", {31'd0, valid_out}, 0);
        chk("rst_active", {31'd0, active}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Three stray bits, then four COMs from an odd phase.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_in = (i != 1);
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hBC, 1'b0);
            settle();
            chk($sformatf("align_active_%0d", i), {31'd0, active}, (i == 3) ? 1 : 0);
        end

        // Data, idle COM, data: two strobes 16 clocks apart.
        send_byte(8'hA5, 1'b1);
        settle();
        chk("a5_valid", {31'd0, valid_out}, 1);
        chk("a5_data", {24'd0, data_out}, 8'hA5);
        t_a5 = cyc;
        send_byte(8'hBC, 1'b0);
        settle();
        chk("bc_no_valid", {31'd0, valid_out}, 0);
        chk("bc_data_held", {24'd0, data_out}, 8'hA5);
        send_byte(8'h3C, 1'b1);
        settle();
        chk("3c_valid", {31'd0, valid_out}, 1);
        chk("3c_gap", cyc - t_a5, 16);

        // Reset mid-symbol while active.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_in = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_active", {31'd0, active}, 0);
        chk("midrst_data", {24'd0, data_out}, 0);
        chk("midrst_valid", {31'd0, valid_out}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Broken alignment: two COMs, a non-COM, then a fresh run of four.
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        settle();
        chk("partial_active", {31'd0, active}, 0);
        send_byte(8'h11, 1'b0);
        settle();
        chk("break_active", {31'd0, active}, 0);
        chk("break_no_valid", {31'd0, valid_out}, 0);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hBC, 1'b0);
            settle();
            chk($sformatf("realign_active_%0d", i), {31'd0, active}, (i == 3) ? 1 : 0);
        end
        send_byte(8'h5A, 1'b1);
        settle();
        chk("5a_data", {24'd0, data_out}, 8'h5A);

        // Electrical idle symbol.
`ifdef S2P_IDLE_EXIT_EN
        send_byte(8'h7C, 1'b0);
        settle();
        chk("idle_exit_active", {31'd0, active}, 0);
        chk("idle_exit_valid", {31'd0, valid_out}, 0);
`else
        send_byte(8'h7C, 1'b1);
        settle();
        chk("7c_valid", {31'd0, valid_out}, 1);
        chk("7c_active", {31'd0, active}, 1);
`endif
        send_byte(8'hBC, 1'b0);
        repeat (4) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
